btb_assoc_2bc: RTL and testbench
================================

// Module: btb_assoc_2bc
// PURPOSE
//  Parametrised fully-associative branch target buffer with per-entry 2-bit saturating
//  direction counters, flush and invalid-first replacement. Fetch looks up pc_in
//  combinationally and gets hit, direction and target. Execute writes resolved branches back.
//  Next generation of the fetch-stage BTB: adds direction hysteresis, not-taken training,
//  flush, non-power-of-two depth and a victim pointer that wraps correctly at any depth.
// PARAMETERS
//  PC_WIDTH     32  width of all PC/target buses
//  BTB_ENTRIES  8   number of entries, >=2, any integer (need not be a power of two)
//  IDX_WIDTH    $clog2(BTB_ENTRIES)  derived, width of victim pointer
//  CNT_ALLOC    2   counter value written on allocation (2 = weakly taken)
// PORTS
//  clk             in   1         core clock
//  reset           in   1         async active-high reset
//  flush           in   1         invalidate all entries (e.g. fence.i / context switch)
//  pc_in           in   PC_WIDTH  fetch PC to look up
//  buffer_hit      out  1         valid entry tag-matches pc_in
//  pred_taken      out  1         buffer_hit && counter[1]
//  next_pc_out     out  PC_WIDTH  stored target if pred_taken, else pc_in
//  is_req_pc       in   1         execute update valid (one branch per cycle)
//  req_pc          in   PC_WIDTH  PC of resolved branch
//  req_taken       in   1         resolved direction
//  predict_target  in   PC_WIDTH  resolved target
// BEHAVIOUR
//  Reset: all valid=0, tags/targets/counters=0, victim ptr=0, so buffer_hit=0,
//   pred_taken=0, next_pc_out=pc_in. Flops use async reset on reset edge.
//  Lookup: purely combinational from current (pre-update) state; 0-cycle latency. An update
//   in cycle N is visible to lookup in cycle N+1, never in N (no bypass).
//  Multiple matches cannot occur by construction. If forced, the lowest index wins.
//  Update (is_req_pc=1, no flush), with req hit computed on req_pc:
//   hit & taken     -> target<=predict_target; cnt<=min(cnt+1,3)
//   hit & !taken    -> cnt<=max(cnt-1,0); target and valid unchanged
//   miss & taken    -> allocate: tag<=req_pc, target<=predict_target, cnt<=CNT_ALLOC, valid<=1
//   miss & !taken   -> no change (not-taken branches are never allocated)
//  Allocation slot: lowest-index invalid entry if any; else entry[victim ptr].
//  Victim ptr advances only when used for allocation. ptr==BTB_ENTRIES-1 wraps to 0.
//   Filling an invalid slot does not move ptr.
//  flush=1: all valid<=0 next edge. Counters, tags and ptr untouched. Flush beats a
//   same-cycle update, which is dropped.
//  Same-cycle lookup and update of the same PC: lookup returns the old entry/old counter.
//  Reset asserted mid-operation clears state immediately. The pending update is lost.
//  Counter is 2-bit unsigned saturating. No arithmetic on PCs (miss -> pc_in; fetch adds 4).
// STRUCTURE
//  Shared package (fetch_pkg): PC_WIDTH, 2-bit counter localparams CNT_SN=0, CNT_WN=1,
//   CNT_WT=2, CNT_ST=3, and the sat_inc/sat_dec functions.
//  Sub-module btb_victim_sel: inputs valid vector and alloc strobe. Outputs alloc index
//   (first-invalid priority encoder, else ptr). Owns the wrapping victim ptr register.
//  Top holds the entry arrays, the two CAM compare vectors (fetch, req) and the output mux.
// TESTING
//  1 reset, pc_in=0x100 -> buffer_hit=0, pred_taken=0, next_pc_out=0x100.
//  2 update req_pc=0x100 taken tgt=0x200. Next cycle pc_in=0x100 -> hit=1, pred_taken=1,
//    next_pc=0x200. Same-cycle lookup during the update -> hit=0.
//  3 hysteresis: entry 0x100 at cnt=2. Not-taken once -> pred_taken=0, buffer_hit=1,
//    next_pc=0x100. Taken twice -> cnt=3. Not-taken once -> still pred_taken=1.
//  4 replacement, BTB_ENTRIES=3: allocate 0x10,0x20,0x30 (slots 0,1,2, ptr stays 0).
//    0x40 -> slot0, ptr=1. 0x50 -> slot1. 0x60 -> slot2, ptr wraps to 0. 0x10 now misses.
//  5 flush with same-cycle taken update of 0x70: next cycle all lookups miss, 0x70 absent.
//    New allocation then goes to slot 0.
//  6 miss & not-taken update 0x80: no entry created. Assert reset mid-stream:
//    outputs drop to miss immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: PC width, 2-bit direction counter encodings
// and the saturating counter helpers.
package fetch_pkg;

  localparam int PC_WIDTH = 32;

  localparam logic [1:0] CNT_SN = 2'd0;
  localparam logic [1:0] CNT_WN = 2'd1;
  localparam logic [1:0] CNT_WT = 2'd2;
  localparam logic [1:0] CNT_ST = 2'd3;

  function automatic logic [1:0] sat_inc(input logic [1:0] cnt);
    return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] cnt);
    return (cnt == CNT_SN) ? CNT_SN : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Allocation slot chooser: lowest-index invalid entry, otherwise a round-robin
// victim pointer that wraps at BTB_ENTRIES-1 for any depth.
module btb_victim_sel #(
  parameter int BTB_ENTRIES = 8,
  parameter int IDX_WIDTH   = $clog2(BTB_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BTB_ENTRIES-1:0] valid,
  input  logic                   alloc,
  output logic [IDX_WIDTH-1:0]   alloc_idx
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(BTB_ENTRIES - 1);

  logic [IDX_WIDTH-1:0] ptr_q;
  logic [IDX_WIDTH-1:0] first_inv;
  logic                 any_invalid;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    any_invalid = 1'b0;
    first_inv   = '0;
    for (int i = BTB_ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        any_invalid = 1'b1;
        first_inv   = IDX_WIDTH'(i);
      end
    end
    alloc_idx = any_invalid ? first_inv : ptr_q;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (alloc && !any_invalid) begin
      ptr_q <= (ptr_q == LAST_IDX) ? '0 : ptr_q + IDX_WIDTH'(1);
    end
  end

endmodule

// File: rtl/btb_assoc_2bc.sv
// Fully-associative branch target buffer with per-entry 2-bit direction counters,
// combinational fetch lookup, execute-stage training and flush.
module btb_assoc_2bc
  import fetch_pkg::*;
#(
  parameter int         PC_WIDTH    = fetch_pkg::PC_WIDTH,
  parameter int         BTB_ENTRIES = 8,
  parameter logic [1:0] CNT_ALLOC   = CNT_WT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [PC_WIDTH-1:0] pc_in,
  output logic                buffer_hit,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] next_pc_out,
  input  logic                is_req_pc,
  input  logic [PC_WIDTH-1:0] req_pc,
  input  logic                req_taken,
  input  logic [PC_WIDTH-1:0] predict_target
);

  localparam int IDX_WIDTH = $clog2(BTB_ENTRIES);

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [PC_WIDTH-1:0]    tag_q [BTB_ENTRIES];
  logic [PC_WIDTH-1:0]    tgt_q [BTB_ENTRIES];
  logic [1:0]             cnt_q [BTB_ENTRIES];

  logic [BTB_ENTRIES-1:0] fetch_match, req_match;
  logic [IDX_WIDTH-1:0]   fetch_idx, req_idx, alloc_idx;
  logic                   req_hit, alloc;

  // Lowest matching index wins should two entries ever share a tag.
  always_comb begin
    fetch_idx = '0;
    req_idx   = '0;
    for (int i = BTB_ENTRIES - 1; i >= 0; i--) begin
      fetch_match[i] = valid_q[i] && (tag_q[i] == pc_in);
      req_match[i]   = valid_q[i] && (tag_q[i] == req_pc);
      if (fetch_match[i]) fetch_idx = IDX_WIDTH'(i);
      if (req_match[i])   req_idx   = IDX_WIDTH'(i);
    end
  end

  assign req_hit     = |req_match;
  assign buffer_hit  = |fetch_match;
  assign pred_taken  = buffer_hit && cnt_q[fetch_idx][1];
  assign next_pc_out = pred_taken ? tgt_q[fetch_idx] : pc_in;

  assign alloc = is_req_pc && !flush && !req_hit && req_taken;

  btb_victim_sel #(
    .BTB_ENTRIES (BTB_ENTRIES),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_victim_sel (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid_q),
    .alloc     (alloc),
    .alloc_idx (alloc_idx)
  );

  // NOTE: the entry arrays are reset explicitly because lookup must see zeros after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= CNT_SN;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else if (is_req_pc) begin
      if (req_hit) begin
        if (req_taken) begin
          tgt_q[req_idx] <= predict_target;
          cnt_q[req_idx] <= sat_inc(cnt_q[req_idx]);
        end else begin
          cnt_q[req_idx] <= sat_dec(cnt_q[req_idx]);
        end
      end else if (req_taken) begin
        valid_q[alloc_idx] <= 1'b1;
        tag_q[alloc_idx]   <= req_pc;
        tgt_q[alloc_idx]   <= predict_target;
        cnt_q[alloc_idx]   <= CNT_ALLOC;
      end
    end
  end

endmodule

// File: tb/tb_btb_assoc_2bc.sv
// Scoreboard bench for btb_assoc_2bc (3-entry instance): expected lookups are queued
// as stimulus is applied and compared at the following falling edge.
module tb_btb_assoc_2bc;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] pc_in;
  logic        buffer_hit;
  logic        pred_taken;
  logic [31:0] next_pc_out;
  logic        is_req_pc;
  logic [31:0] req_pc;
  logic        req_taken;
  logic [31:0] predict_target;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] nxt;
  } exp_t;

  exp_t  exp_q [$];
  string tag_q [$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  btb_assoc_2bc #(
    .PC_WIDTH    (32),
    .BTB_ENTRIES (3),
    .CNT_ALLOC   (2'd2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .pc_in          (pc_in),
    .buffer_hit     (buffer_hit),
    .pred_taken     (pred_taken),
    .next_pc_out    (next_pc_out),
    .is_req_pc      (is_req_pc),
    .req_pc         (req_pc),
    .req_taken      (req_taken),
    .predict_target (predict_target)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Queue the expected lookup result for the current pc_in.
  task automatic expect_out(input string tag, input logic hit, input logic taken,
                            input logic [31:0] nxt);
    exp_t e;
    e.hit = hit; e.taken = taken; e.nxt = nxt;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Sample at the falling edge, score pending expectations, then advance past the next rise.
  task automatic step();
    exp_t  e;
    string t;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, "_hit"},   {31'b0, buffer_hit}, {31'b0, e.hit});
      check({t, "_taken"}, {31'b0, pred_taken}, {31'b0, e.taken});
      check({t, "_next"},  next_pc_out,         e.nxt);
    end
    @(posedge clk);
    #1;
    is_req_pc = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic taken, input logic [31:0] nxt);
    pc_in = pc;
    expect_out(tag, hit, taken, nxt);
    step();
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    is_req_pc      = 1'b1;
    req_pc         = pc;
    req_taken      = taken;
    predict_target = tgt;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; pc_in = 32'h100;
    is_req_pc = 1'b0; req_pc = '0; req_taken = 1'b0; predict_target = '0;

    // Reset state
    expect_out("rst", 1'b0, 1'b0, 32'h100);
    step();
    reset = 1'b0;
    look("idle", 32'h100, 1'b0, 1'b0, 32'h100);

    // Allocation, with no same-cycle bypass
    upd(32'h100, 1'b1, 32'h200);
    look("alloc_same", 32'h100, 1'b0, 1'b0, 32'h100);
    look("alloc_next", 32'h100, 1'b1, 1'b1, 32'h200);

    // Hysteresis: cnt 2 -> 1 -> 2 -> 3 -> 2 -> 1; second taken retargets to 0x300
    upd(32'h100, 1'b0, 32'h0);
    look("nt_same", 32'h100, 1'b1, 1'b1, 32'h200);
    look("nt1", 32'h100, 1'b1, 1'b0, 32'h100);
    upd(32'h100, 1'b1, 32'h200);
    step();
    look("t1", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 1'b1, 32'h300);
    step();
    upd(32'h100, 1'b0, 32'h0);
    step();
    look("st_nt", 32'h100, 1'b1, 1'b1, 32'h300);
    upd(32'h100, 1'b0, 32'h0);
    step();
    look("wt_nt", 32'h100, 1'b1, 1'b0, 32'h100);

    // Async reset mid-cycle drops the entry at once and loses the pending update
    upd(32'h90, 1'b1, 32'h900);
    reset = 1'b1;
    look("rst_async", 32'h100, 1'b0, 1'b0, 32'h100);
    reset = 1'b0;
    look("rst_lost", 32'h90, 1'b0, 1'b0, 32'h90);

    // Replacement on 3 entries
    upd(32'h10, 1'b1, 32'h1010); step();
    upd(32'h20, 1'b1, 32'h1020); step();
    upd(32'h30, 1'b1, 32'h1030); step();
    look("fill_10", 32'h10, 1'b1, 1'b1, 32'h1010);
    look("fill_30", 32'h30, 1'b1, 1'b1, 32'h1030);
    upd(32'h40, 1'b1, 32'h1040); step();
    look("evict_10", 32'h10, 1'b0, 1'b0, 32'h10);
    look("keep_20", 32'h20, 1'b1, 1'b1, 32'h1020);
    upd(32'h50, 1'b1, 32'h1050); step();
    upd(32'h60, 1'b1, 32'h1060); step();
    look("evict_20", 32'h20, 1'b0, 1'b0, 32'h20);
    look("evict_30", 32'h30, 1'b0, 1'b0, 32'h30);
    look("new_40", 32'h40, 1'b1, 1'b1, 32'h1040);
    look("new_60", 32'h60, 1'b1, 1'b1, 32'h1060);

    // Flush beats same-cycle update; lookup in the flush cycle still sees old state
    upd(32'h70, 1'b1, 32'h1070);
    flush = 1'b1;
    look("flush_same", 32'h60, 1'b1, 1'b1, 32'h1060);
    look("flush_40", 32'h40, 1'b0, 1'b0, 32'h40);
    look("flush_60", 32'h60, 1'b0, 1'b0, 32'h60);
    look("flush_70", 32'h70, 1'b0, 1'b0, 32'h70);

    // Refill from slot 0; ptr (0 after wrap) then evicts slot 0 again
    upd(32'hA0, 1'b1, 32'h10A0); step();
    upd(32'hB0, 1'b1, 32'h10B0); step();
    upd(32'hC0, 1'b1, 32'h10C0); step();
    upd(32'hD0, 1'b1, 32'h10D0); step();
    look("refill_A0", 32'hA0, 1'b0, 1'b0, 32'hA0);
    look("refill_B0", 32'hB0, 1'b1, 1'b1, 32'h10B0);
    look("refill_D0", 32'hD0, 1'b1, 1'b1, 32'h10D0);

    // Not-taken miss never allocates
    upd(32'h80, 1'b0, 32'h1080); step();
    look("nt_miss_80", 32'h80, 1'b0, 1'b0, 32'h80);
    look("nt_miss_B0", 32'hB0, 1'b1, 1'b1, 32'h10B0);
    look("nt_miss_C0", 32'hC0, 1'b1, 1'b1, 32'h10C0);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
